pipe_skid_buffer: RTL and testbench

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_data_reg.sv | 22 ++
 rtl/pipe_skid_buffer.sv | 100 ++++++++++
 tb/tb_pipe_skid_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline skid buffer.
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned OCC_W         = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  // Entry count held in each state.
  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      ONE:     occ_of = OCC_W'(1);
      FULL:    occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide storage register with write enable and async active-low clear.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: registered ready/valid on both sides, main + skid storage.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  state_t           state_q;
  state_t           state_d;
  logic             push_c;
  logic             pop_c;
  logic             main_en_c;
  logic             skid_en_c;
  logic [WIDTH-1:0] main_d_c;
  logic [WIDTH-1:0] skid_q;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // State plus handshake/occupancy flops, all derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != FULL);
      out_valid <= (state_d != EMPTY);
      occupancy <= occ_of(state_d);
    end
  end

  // Next state and storage load enables; flush overrides any transfer.
  always_comb begin
    state_d   = state_q;
    main_en_c = 1'b0;
    skid_en_c = 1'b0;
    main_d_c  = in_data;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_c) begin
            state_d   = ONE;
            main_en_c = 1'b1;
          end
        end
        ONE: begin
          if (push_c && !pop_c) begin
            state_d   = FULL;
            skid_en_c = 1'b1;
          end else if (push_c && pop_c) begin
            main_en_c = 1'b1;
          end else if (pop_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop_c) begin
            state_d   = ONE;
            main_en_c = 1'b1;
            main_d_c  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en_c),
    .d   (main_d_c),
    .q   (out_data)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en_c),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and randomized scenarios for pipe_skid_buffer with a queue scoreboard.
module tb_pipe_skid_buffer;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;

  int checks   = 0;
  int failures = 0;

  pipe_skid_buffer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b occ=%0d data=%h, want 0 1 0 0000",
               out_valid, in_ready, occupancy, out_data);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single_pass();
    in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL single_push: valid=%b data=%h occ=%0d, want 1 a5a5 1", out_valid, out_data, occupancy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL single_pop: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0001;
    tick();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: occ=%0d ready=%b, want 1 1", occupancy, in_ready);
    end
    in_data = 16'h0002;
    tick();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h0001) begin
      failures++;
      $display("FAIL bp_full: occ=%0d ready=%b data=%h, want 2 0 0001", occupancy, in_ready, out_data);
    end
    in_data = 16'h0003;
    tick();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h0001) begin
      failures++;
      $display("FAIL bp_hold: occ=%0d ready=%b data=%h, want 2 0 0001", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 16'h0002 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain2: data=%h occ=%0d ready=%b, want 0002 1 1", out_data, occupancy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 16'h0003 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain3: data=%h occ=%0d valid=%b, want 0003 1 1", out_data, occupancy, out_valid);
    end
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: occ=%0d valid=%b, want 0 0", occupancy, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = W'(i + 16'h0100);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i + 16'h0100) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%b data=%h occ=%0d ready=%b, want 1 %h 1 1",
                 i, out_valid, out_data, occupancy, in_ready, W'(i + 16'h0100));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (occupancy !== 2'd0) begin
      failures++;
      $display("FAIL stream_drain: occ=%0d, want 0", occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h1111; tick();
    in_data = 16'h2222; tick();
    checks++;
    if (occupancy !== 2'd2) begin
      failures++;
      $display("FAIL flush_setup: occ=%0d, want 2", occupancy);
    end
    flush = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: valid=%b occ=%0d ready=%b, want 0 0 1", out_valid, occupancy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_data !== 16'h1111 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_hold[%0d]: data=%h valid=%b, want 1111 0", i, out_data, out_valid);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic         push;
    logic         pop;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 5);
      in_data   = W'($urandom);
      checks++;
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0) ||
          in_ready !== (q.size() < 2) || (q.size() > 0 && out_data !== q[0])) begin
        failures++;
        $display("FAIL random[%0d]: occ=%0d valid=%b ready=%b data=%h, want occ=%0d head=%h",
                 cyc, occupancy, out_valid, in_ready, out_data, q.size(),
                 (q.size() > 0) ? q[0] : 16'h0);
      end
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(in_data);
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h3333; tick();
    in_data = 16'h4444; tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b ready=%b occ=%0d data=%h, want 0 1 0 0000",
               out_valid, in_ready, occupancy, out_data);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h5A5A;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h5A5A || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL reset_repush: valid=%b data=%h occ=%0d, want 1 5a5a 1", out_valid, out_data, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
